// File: rtl/ieee_to_fp_11_21_if.sv
// Valid/ready handshake bundle for the IEEE single to FloPoCo 11/21 converter.
// slave is the converter side, master the producer/consumer side.
interface ieee_to_fp_11_21_if #(
  parameter int unsigned width = 34
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [width:0]   out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ieee_to_fp_11_21.sv
// IEEE-754 single -> FloPoCo wE=11/wF=21 converter: classify, normalize, round/pack.
// Three elastic stages; a stall at the output back-pressures the input.
module ieee_to_fp_11_21 #(
  parameter int unsigned width     = 34,
  parameter int unsigned BIAS_DIFF = 896
) (
  input  logic               clk,
  input  logic               rst,
  ieee_to_fp_11_21_if.slave  bus
);

  typedef enum logic [1:0] {
    ExcZero = 2'b00,
    ExcNorm = 2'b01,
    ExcInf  = 2'b10,
    ExcNan  = 2'b11
  } exc_e;

  // Exponents stay within 874..1151, so 11 bits carry the arithmetic exactly.
  localparam logic [10:0] Bias = 11'(BIAS_DIFF);

  // Stage 1: classification
  logic        s1_valid_q;
  logic        s1_sign_q;
  exc_e        s1_exc_q, s1_exc_d;
  logic        s1_sub_q, s1_sub_d;
  logic [7:0]  s1_exp_q;
  logic [22:0] s1_man_q;
  logic [4:0]  s1_lzc_q, s1_lzc_d;

  // Stage 2: normalized exponent and 23-bit fraction
  logic        s2_valid_q;
  logic        s2_sign_q;
  exc_e        s2_exc_q;
  logic [10:0] s2_e_q, s2_e_d;
  logic [22:0] s2_f_q, s2_f_d;

  // Stage 3: packed output word
  logic        s3_valid_q;
  logic [width:0] s3_word_q, s3_word_d;

  logic s1_en, s2_en, s3_en;

  // A stage may load when empty or when its current content leaves this cycle.
  always_comb begin
    s3_en = !s3_valid_q || bus.out_ready;
    s2_en = !s2_valid_q || s3_en;
    s1_en = !s1_valid_q || s2_en;
  end

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s3_valid_q;
  assign bus.out_data  = s3_word_q;

  logic [7:0]  in_exp;
  logic [22:0] in_man;

  always_comb begin
    in_exp   = bus.in_data[30:23];
    in_man   = bus.in_data[22:0];
    s1_exc_d = ExcNorm;
    if (in_exp == 8'hff) begin
      s1_exc_d = (in_man == 23'd0) ? ExcInf : ExcNan;
    end else if ((in_exp == 8'd0) && (in_man == 23'd0)) begin
      s1_exc_d = ExcZero;
    end
    s1_sub_d = (in_exp == 8'd0);
    // Highest set bit wins, giving the leading-zero count of the mantissa.
    s1_lzc_d = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (in_man[i]) begin
        s1_lzc_d = 5'(22 - i);
      end
    end
  end

  logic [23:0] sub_shift;

  always_comb begin
    // {man,0} << lzc drops the leading one into bit 23, leaving the hidden-bit-free fraction.
    sub_shift = {s1_man_q, 1'b0} << s1_lzc_q;
    if (s1_sub_q) begin
      s2_e_d = Bias - {6'd0, s1_lzc_q};
      s2_f_d = sub_shift[22:0];
    end else begin
      s2_e_d = {3'd0, s1_exp_q} + Bias;
      s2_f_d = s1_man_q;
    end
  end

  logic        round_up;
  logic [21:0] frac_sum;
  logic [10:0] e_rnd;

  always_comb begin
    round_up = s2_f_q[1] && (s2_f_q[0] || s2_f_q[2]);
    frac_sum = {1'b0, s2_f_q[22:2]} + {21'd0, round_up};
    e_rnd    = s2_e_q + {10'd0, frac_sum[21]};
    case (s2_exc_q)
      ExcNorm: s3_word_d = {ExcNorm, s2_sign_q, e_rnd, frac_sum[20:0]};
      ExcNan:  s3_word_d = {ExcNan, 1'b0, 32'd0};
      default: s3_word_d = {s2_exc_q, s2_sign_q, 32'd0};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exc_q   <= ExcZero;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= 8'd0;
      s1_man_q   <= 23'd0;
      s1_lzc_q   <= 5'd0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exc_q   <= ExcZero;
      s2_e_q     <= 11'd0;
      s2_f_q     <= 23'd0;
      s3_valid_q <= 1'b0;
      s3_word_q  <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign_q <= bus.in_data[31];
          s1_exc_q  <= s1_exc_d;
          s1_sub_q  <= s1_sub_d;
          s1_exp_q  <= in_exp;
          s1_man_q  <= in_man;
          s1_lzc_q  <= s1_lzc_d;
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_sign_q <= s1_sign_q;
          s2_exc_q  <= s1_exc_q;
          s2_e_q    <= s2_e_d;
          s2_f_q    <= s2_f_d;
        end
      end
      if (s3_en) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_word_q <= s3_word_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_ieee_to_fp_11_21.sv
// Directed bench for ieee_to_fp_11_21: hand-computed vectors, back-pressure, streaming, reset.
module tb_ieee_to_fp_11_21;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ieee_to_fp_11_21_if #(.width(34)) bus ();

  ieee_to_fp_11_21 #(.width(34), .BIAS_DIFF(896)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  int n, acc, got;
  logic [31:0] vin  [128];
  logic [34:0] vexp [128];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent model: subnormal exponent from the top-bit position, rounding by remainder.
  function automatic logic [34:0] ref_conv(input logic [31:0] x);
    int unsigned ex, m, e, f, q, p;
    ex = 32'(x[30:23]);
    m  = 32'(x[22:0]);
    if (ex == 255) return (m != 0) ? 35'h600000000 : {2'b10, x[31], 32'd0};
    if (ex == 0 && m == 0) return {2'b00, x[31], 32'd0};
    if (ex == 0) begin
      p = 0;
      for (int i = 0; i < 23; i++) if (m[i]) p = i;
      e = 874 + p;
      f = (m << (23 - p)) & 32'h7fffff;
    end else begin
      e = ex + 896;
      f = m;
    end
    q = f >> 2;
    if ((f & 3) == 3 || ((f & 3) == 2 && (q & 1) == 1)) q++;
    if (q == (1 << 21)) begin
      q = 0;
      e++;
    end
    return {2'b01, x[31], e[10:0], q[20:0]};
  endfunction

  // Starts just after a negedge; checks three-cycle latency and the value.
  task automatic single(input string tag, input logic [31:0] x, input logic [34:0] e);
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    bus.out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    check({tag, " early1"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check({tag, " early2"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check({tag, " valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, " data"}, 64'(bus.out_data), 64'(e));
    @(negedge clk);
    check({tag, " drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  // One handshake cycle: consume and feed before the edge, then move to the next negedge.
  task automatic cycle(input logic ordy);
    bus.out_ready = ordy;
    bus.in_valid  = (acc < n);
    bus.in_data   = (acc < n) ? vin[acc] : 32'd0;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      check($sformatf("seq[%0d]", got), 64'(bus.out_data), 64'(vexp[got % 128]));
      got++;
    end
    if (bus.in_valid && bus.in_ready) acc++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] x;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b0;
    n = 0; acc = 0; got = 0;
    #12;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset out_data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release in_ready", 64'(bus.in_ready), 64'd1);

    single("one",      32'h3F800000, 35'h27FE00000);
    single("negzero",  32'h80000000, 35'h100000000);
    single("inf",      32'h7F800000, 35'h400000000);
    single("neginf",   32'hFF800000, 35'h500000000);
    single("nan",      32'hFFC00000, 35'h600000000);
    single("nan_pl",   32'h7F800001, 35'h600000000);
    single("rnd_up",   32'h3F800003, 35'h27FE00001);
    single("rnd_tie",  32'h3F800002, 35'h27FE00000);
    single("rnd_cy",   32'h3FFFFFFF, 35'h280000000);
    single("negpi",    32'hC0490FDB, 35'h3801243F7);
    single("maxnorm",  32'h7F7FFFFF, 35'h28FE00000);
    single("sub_min",  32'h00000001, 35'h26D400000);
    // 0x00400000 is 2^-127, biased exponent 1023-127 = 896
    single("sub_half", 32'h00400000, 35'h270000000);

    // Back-pressure: five items against a stalled output
    vin[0] = 32'h3F800000; vexp[0] = 35'h27FE00000;
    vin[1] = 32'h80000000; vexp[1] = 35'h100000000;
    vin[2] = 32'h7F800000; vexp[2] = 35'h400000000;
    vin[3] = 32'hFFC00000; vexp[3] = 35'h600000000;
    vin[4] = 32'h3F800003; vexp[4] = 35'h27FE00001;
    n = 5; acc = 0; got = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0);
      if (k >= 3) begin
        check("bp hold valid", 64'(bus.out_valid), 64'd1);
        check("bp hold data", 64'(bus.out_data), 64'(vexp[0]));
      end
    end
    check("bp accepted", 64'(acc), 64'd3);
    check("bp in_ready", 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < 40 && got < n; k++) cycle(1'b1);
    check("bp outputs", 64'(got), 64'd5);
    check("bp inputs", 64'(acc), 64'd5);
    check("bp empty", 64'(bus.out_valid), 64'd0);

    // Streaming: 100 random operands with forced subnormal/special exponents mixed in
    for (int i = 0; i < 100; i++) begin
      x = $urandom;
      if (i % 5 == 0) x[30:23] = 8'h00;
      if (i % 17 == 3) x[30:23] = 8'hff;
      vin[i]  = x;
      vexp[i] = ref_conv(x);
    end
    n = 100; acc = 0; got = 0; cyc = 0;
    for (int k = 0; k < 300 && got < n; k++) begin
      cycle(1'b1);
      cyc++;
    end
    check("stream outputs", 64'(got), 64'd100);
    check("stream cycles", 64'(cyc), 64'd103);
    check("stream empty", 64'(bus.out_valid), 64'd0);

    // Reset with two items in flight
    vin[0] = 32'h3F800000; vexp[0] = 35'h27FE00000;
    vin[1] = 32'h40000000; vexp[1] = 35'h280000000;
    n = 2; acc = 0; got = 0;
    repeat (3) cycle(1'b0);
    check("pre-reset valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("reset flush valid", 64'(bus.out_valid), 64'd0);
    check("reset flush data", 64'(bus.out_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("post-reset idle[%0d]", k), 64'(bus.out_valid), 64'd0);
    end
    single("after_rst", 32'h3F800000, 35'h27FE00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
